pe_port_vc_buffer: RTL and testbench
====================================

// Module: pe_port_vc_buffer
// PURPOSE
//  Router-side PE port of the ring node; sits directly downstream of the NIC's network output.
//  Accepts packets the NIC launches (NIC net_so/net_do, NIC net_ro driven from here) into two
//  single-entry virtual-channel buffers (VC0 even, VC1 odd) and presents them to the router arbiter.
//  Generates the node polarity that both the NIC and the router use.
// PARAMETERS
//  DW      64  packet width
//  VC_BIT  63  packet bit carrying the virtual channel
//  DIR_BIT 62  packet bit carrying the direction (0 = clockwise, 1 = counter-clockwise)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  polarity     out  1   node polarity; goes to NIC net_polarity and the router
//  pe_si        in   1   NIC net_so: valid packet on pe_di
//  pe_ri        out  1   to NIC net_ro: buffer space for a new packet this cycle
//  pe_di        in   DW  NIC net_do: packet
//  out_valid    out  1   buffered packet available to the router arbiter
//  out_dir      out  1   direction bit of the presented packet
//  out_data     out  DW  presented packet
//  out_grant    in   1   arbiter accepts the presented packet this cycle
//  protocol_err out  1   sticky: pe_si seen while pe_ri was low
// BEHAVIOUR
//  Reset, async while reset==0:
//   - polarity=0; buf0/buf1 empty; data regs cleared to 0; protocol_err=0.
//   - out_valid=0, out_dir=0, out_data=0, pe_ri=0 while reset is held.
//  Polarity: toggles on every rising edge after reset is released; first post-reset cycle has
//   polarity=0.
//  VC slots: VC v is router-readable only when polarity==v; PE-writable only when polarity!=v.
//   Read and write therefore never target the same buffer in one cycle.
//  Ingress (all combinational outputs):
//   - pe_ri = ~full[~polarity] (reset released).
//   - If pe_si && pe_ri: buffer[~polarity] <= pe_di, with bit VC_BIT overwritten by ~polarity.
//     full[~polarity] <= 1 at that edge.
//   - If pe_si && !pe_ri: packet dropped, buffers unchanged, protocol_err <= 1. It clears only
//     on reset.
//  Egress (all combinational outputs):
//   - out_valid = full[polarity]. out_data = buffer[polarity] when out_valid, else 0.
//     out_dir = out_data[DIR_BIT].
//   - If out_valid && out_grant: full[polarity] <= 0 at that edge.
//   - out_grant with out_valid=0 is ignored.
//   - An ungranted packet stays and is re-presented two cycles later, when its polarity returns.
//  Latency: a packet accepted at edge N (polarity p at N-1) is presented at cycle N, polarity ~p,
//   i.e. one cycle min.
//  Simultaneous accept and grant in one cycle is always legal: they act on different VCs.
//  Back-to-back: the PE can push one packet per cycle only while both VCs keep draining.
//  Reset mid-operation discards both buffers; no partial packet survives.
// TESTING
//  1 Reset release, idle -> polarity 0,1,0,1..; pe_ri=1; out_valid=0; protocol_err=0.
//  2 pe_si=1, pe_di=64'h0000_0000_DEAD_BEEF at polarity 0, out_grant=1 ->
//    next cycle out_valid=1, out_data=64'h8000_0000_DEAD_BEEF, out_dir=0; buffer then empty.
//  3 Write packet with bit62=1 into VC1 and hold out_grant=0 for 6 cycles ->
//    out_valid=1 only on polarity=1 cycles; packet is unchanged.
//    pe_ri=0 on polarity=0 cycles.
//  4 With VC1 full, drive pe_si=1 at polarity=0 -> packet dropped, protocol_err=1 sticky,
//    VC1 contents intact.
//  5 Stream 8 packets, one per cycle, with out_grant=1 -> all 8 appear in order on out_data,
//    one cycle later each; no errors.
//  6 Assert reset low while both VCs are full -> outputs go to reset values immediately;
//    after release both VCs are empty.

Source files
------------

// File: rtl/pe_port_vc_buffer.sv
// pe_port_vc_buffer
// Router-side PE port of a ring node. Packets launched by the NIC land in one of two
// single-entry virtual-channel buffers (VC0 even, VC1 odd) and are presented to the
// router arbiter. The node polarity toggles every cycle and decides which VC the PE may
// write (polarity != v) and which VC the router may read (polarity == v). A read and a
// write therefore never target the same buffer in the same cycle.

module pe_port_vc_buffer #(
    parameter int DW      = 64,
    parameter int VC_BIT  = 63,
    parameter int DIR_BIT = 62
) (
    input  logic          clk,
    input  logic          reset,
    output logic          polarity,
    input  logic          pe_si,
    output logic          pe_ri,
    input  logic [DW-1:0] pe_di,
    output logic          out_valid,
    output logic          out_dir,
    output logic [DW-1:0] out_data,
    input  logic          out_grant,
    output logic          protocol_err
);

    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic [1:0]    full;
    logic          wr_vc;
    logic          write_en;
    logic          drop;
    logic          grant_en;
    logic [DW-1:0] wr_pkt;

    // The writable VC is always the one the router is not currently reading
    assign wr_vc    = ~polarity;
    assign pe_ri    = reset & ~full[wr_vc];
    assign write_en = pe_si & pe_ri;
    assign drop     = pe_si & ~pe_ri;
    assign grant_en = out_valid & out_grant;

    // Stamp the VC bit of the incoming packet with the buffer it is stored in
    always_comb begin
        wr_pkt         = pe_di;
        wr_pkt[VC_BIT] = wr_vc;
    end

    // Present the readable VC to the arbiter; data is forced to zero when nothing is valid
    always_comb begin
        out_valid = full[polarity];
        out_data  = '0;
        if (out_valid) begin
            out_data = polarity ? buf1 : buf0;
        end
        out_dir = out_data[DIR_BIT];
    end

    // Node polarity flips on every rising edge once out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity <= 1'b0;
        end else begin
            polarity <= ~polarity;
        end
    end

    // Buffer storage: accept into the writable VC, release the readable VC on grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf0 <= '0;
            buf1 <= '0;
            full <= 2'b00;
        end else begin
            if (write_en) begin
                if (wr_vc) begin
                    buf1 <= wr_pkt;
                end else begin
                    buf0 <= wr_pkt;
                end
                full[wr_vc] <= 1'b1;
            end
            if (grant_en) begin
                full[polarity] <= 1'b0;
            end
        end
    end

    // Sticky flag for a packet pushed while no buffer space was offered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            protocol_err <= 1'b0;
        end else if (drop) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_port_vc_buffer.sv
// tb_pe_port_vc_buffer
// Directed bench for the PE port VC buffer. Inputs change 1ns after each rising edge and
// outputs are checked before the next rising edge. The bench tracks the expected node
// polarity itself and compares against hand-computed packet values.

module tb_pe_port_vc_buffer;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        pe_si;
    logic        pe_ri;
    logic [63:0] pe_di;
    logic        out_valid;
    logic        out_dir;
    logic [63:0] out_data;
    logic        out_grant;
    logic        protocol_err;

    int          checks;
    int          failures;
    logic        exp_pol;
    logic        wpol;
    logic [63:0] exp_pkt;
    logic [63:0] pkts [8];

    pe_port_vc_buffer #(
        .DW(64),
        .VC_BIT(63),
        .DIR_BIT(62)
    ) dut (
        .clk(clk),
        .reset(reset),
        .polarity(polarity),
        .pe_si(pe_si),
        .pe_ri(pe_ri),
        .pe_di(pe_di),
        .out_valid(out_valid),
        .out_dir(out_dir),
        .out_data(out_data),
        .out_grant(out_grant),
        .protocol_err(protocol_err)
    );

    // 10ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts the failure and reports it
    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the expected polarity flips with it
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        exp_pol = ~exp_pol;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_pol   = 1'b0;
        reset     = 1'b0;
        pe_si     = 1'b0;
        pe_di     = '0;
        out_grant = 1'b0;

        // Reset held: everything at reset values
        #3;
        check_output("rst_polarity", {63'd0, polarity}, 64'd0);
        check_output("rst_pe_ri", {63'd0, pe_ri}, 64'd0);
        check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_output("rst_out_data", out_data, 64'd0);
        check_output("rst_protocol_err", {63'd0, protocol_err}, 64'd0);

        // 1: release reset, idle toggling
        #9;
        reset   = 1'b1;
        exp_pol = 1'b0;
        #1;
        $display("[TB] idle after reset release");
        for (int i = 0; i < 4; i++) begin
            check_output("idle_polarity", {63'd0, polarity}, {63'd0, exp_pol});
            check_output("idle_pe_ri", {63'd0, pe_ri}, 64'd1);
            check_output("idle_out_valid", {63'd0, out_valid}, 64'd0);
            check_output("idle_protocol_err", {63'd0, protocol_err}, 64'd0);
            apply_stimulus();
        end

        // 2: single packet at polarity 0 lands in VC1 with VC bit set
        $display("[TB] single packet");
        check_output("t2_pol0", {63'd0, polarity}, 64'd0);
        pe_si     = 1'b1;
        pe_di     = 64'h0000_0000_DEAD_BEEF;
        out_grant = 1'b1;
        check_output("t2_pe_ri", {63'd0, pe_ri}, 64'd1);
        apply_stimulus();
        pe_si = 1'b0;
        check_output("t2_out_valid", {63'd0, out_valid}, 64'd1);
        check_output("t2_out_data", out_data, 64'h8000_0000_DEAD_BEEF);
        check_output("t2_out_dir", {63'd0, out_dir}, 64'd0);
        apply_stimulus();
        check_output("t2_vc0_empty", {63'd0, out_valid}, 64'd0);
        apply_stimulus();
        check_output("t2_vc1_drained", {63'd0, out_valid}, 64'd0);
        check_output("t2_out_data_zero", out_data, 64'd0);

        // 5: stream 8 packets back to back with the arbiter always granting
        $display("[TB] streaming");
        pkts[0] = 64'h0123_4567_89AB_CDEF;
        pkts[1] = 64'hFEDC_BA98_7654_3210;
        pkts[2] = 64'h4000_0000_0000_0001;
        pkts[3] = 64'h8000_0000_0000_0002;
        pkts[4] = 64'h0000_0000_0000_0003;
        pkts[5] = 64'hC000_0000_0000_0004;
        pkts[6] = 64'h5555_AAAA_5555_AAAA;
        pkts[7] = 64'hAAAA_5555_AAAA_5555;
        for (int k = 0; k < 8; k++) begin
            check_output("t5_pe_ri", {63'd0, pe_ri}, 64'd1);
            pe_si = 1'b1;
            pe_di = pkts[k];
            wpol  = exp_pol;
            apply_stimulus();
            exp_pkt     = pkts[k];
            exp_pkt[63] = ~wpol;
            check_output("t5_out_valid", {63'd0, out_valid}, 64'd1);
            check_output("t5_out_data", out_data, exp_pkt);
            check_output("t5_out_dir", {63'd0, out_dir}, {63'd0, exp_pkt[62]});
        end
        pe_si = 1'b0;
        apply_stimulus();
        check_output("t5_drained", {63'd0, out_valid}, 64'd0);
        check_output("t5_no_err", {63'd0, protocol_err}, 64'd0);
        if (exp_pol) apply_stimulus();

        // 3: packet with bit62 set held in VC1 without grant
        $display("[TB] held packet");
        check_output("t3_pol0", {63'd0, polarity}, 64'd0);
        out_grant = 1'b0;
        pe_si     = 1'b1;
        pe_di     = 64'h4000_0000_1234_5678;
        apply_stimulus();
        pe_si = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_output("t3_out_valid", {63'd0, out_valid}, {63'd0, exp_pol});
            if (exp_pol) begin
                check_output("t3_out_data", out_data, 64'hC000_0000_1234_5678);
                check_output("t3_out_dir", {63'd0, out_dir}, 64'd1);
            end else begin
                check_output("t3_pe_ri", {63'd0, pe_ri}, 64'd0);
            end
            apply_stimulus();
        end

        // 4: push while VC1 is full at polarity 0
        $display("[TB] protocol error");
        apply_stimulus();
        check_output("t4_pol0", {63'd0, polarity}, 64'd0);
        check_output("t4_pe_ri", {63'd0, pe_ri}, 64'd0);
        pe_si = 1'b1;
        pe_di = 64'hFFFF_FFFF_FFFF_FFFF;
        apply_stimulus();
        pe_si = 1'b0;
        check_output("t4_err_set", {63'd0, protocol_err}, 64'd1);
        check_output("t4_vc1_intact", out_data, 64'hC000_0000_1234_5678);
        apply_stimulus();
        apply_stimulus();
        check_output("t4_err_sticky", {63'd0, protocol_err}, 64'd1);
        check_output("t4_vc1_still", out_data, 64'hC000_0000_1234_5678);

        // 6: fill VC0 too, then reset mid-operation
        $display("[TB] reset with both VCs full");
        check_output("t6_pe_ri", {63'd0, pe_ri}, 64'd1);
        pe_si = 1'b1;
        pe_di = 64'h8000_0000_AAAA_5555;
        apply_stimulus();
        pe_si = 1'b0;
        check_output("t6_vc0_valid", {63'd0, out_valid}, 64'd1);
        check_output("t6_vc0_data", out_data, 64'h0000_0000_AAAA_5555);
        check_output("t6_full_pe_ri", {63'd0, pe_ri}, 64'd0);
        reset = 1'b0;
        #2;
        check_output("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_output("t6_rst_out_data", out_data, 64'd0);
        check_output("t6_rst_pe_ri", {63'd0, pe_ri}, 64'd0);
        check_output("t6_rst_polarity", {63'd0, polarity}, 64'd0);
        check_output("t6_rst_err", {63'd0, protocol_err}, 64'd0);
        #2;
        reset   = 1'b1;
        exp_pol = 1'b0;
        #1;
        check_output("t6_post_valid0", {63'd0, out_valid}, 64'd0);
        check_output("t6_post_pe_ri0", {63'd0, pe_ri}, 64'd1);
        apply_stimulus();
        check_output("t6_post_pol1", {63'd0, polarity}, 64'd1);
        check_output("t6_post_valid1", {63'd0, out_valid}, 64'd0);
        check_output("t6_post_pe_ri1", {63'd0, pe_ri}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
